mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Multi-cycle MIPS control FSM that sits directly upstream of the multi-cycle datapath and drives all of its control inputs.
- Decodes OP/Fun from the datapath instruction register and sequences each instruction through IF/ID/EX/MEM/WB.
- Stalls in memory states until the memory/IO bus returns MIO_ready.
- Replaces the external control stimulus used on the single-cycle datapath.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (S_IF).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- OP  input  6  instruction[31:26].
- Fun  input  6  instruction[5:0].
- MIO_ready  input  1  memory transfer complete this cycle.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IorD  output  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  load the instruction register.
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  PC load if zero (beq).
- BranchN  output  1  PC load if !zero (bne).
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUSrc_A  output  1  0 = PC, 1 = register A.
- ALUSrc_B  output  2  00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- ALU_Control  output  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- RegDst  output  2  00 = rt, 01 = rd, 10 = $31.
- MemtoReg  output  2  00 = ALUOut, 01 = MDR, 10 = PC.
- RegWrite  output  1  register file write.
- illegal  output  1  undecodable instruction flag.
- state_out  output  4  current state, for debug.

Behaviour:
- Moore FSM on a 4-bit state register. Asynchronous reset to S_IF.
- While rst=1, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0. Reset mid-instruction aborts the instruction with no further writes.
- Outputs default to 0 in every state; only the assertions listed below apply.
- S_IF(0): MemRead=1, ALUSrc_B=01, ALU_Control=010. IRWrite and PCWrite equal MIO_ready (the only Mealy terms). Stay while !MIO_ready, else go to S_ID.
- S_ID(1): ALUSrc_B=11, ALU_Control=010 (branch target precomputed). Next state by OP:
  - 100011 (lw) or 101011 (sw) -> S_MA.
  - 000000 -> S_REX if Fun is legal, else S_TRAP.
  - 000100 (beq) or 000101 (bne) -> S_BR.
  - 000010 (j) -> S_J.
  - 000011 (jal) -> S_JAL.
  - 001000 (addi) or 001010 (slti) -> S_IEX.
  - Anything else -> S_TRAP.
- S_MA(2): ALUSrc_A=1, ALUSrc_B=10, ALU_Control=010. lw -> S_MR, sw -> S_MW.
- S_MR(3): MemRead=1, IorD=1. Wait for MIO_ready, then S_LWB.
- S_LWB(4): RegDst=00, MemtoReg=01, RegWrite=1. Then S_IF.
- S_MW(5): MemWrite=1, IorD=1. Wait for MIO_ready, then S_IF.
- S_REX(6): ALUSrc_A=1, ALUSrc_B=00. ALU_Control from Fun: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 100110 -> 011, 100111 -> 100, 101010 -> 111, 000010 -> 101. Then S_RWB.
- S_RWB(7): RegDst=01, MemtoReg=00, RegWrite=1. Then S_IF.
- S_BR(8): ALUSrc_A=1, ALUSrc_B=00, ALU_Control=110, PCSource=01. Branch=1 if OP=000100, BranchN=1 if OP=000101. Then S_IF.
- S_J(9): PCSource=10, PCWrite=1. Then S_IF.
- S_JAL(10): PCSource=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1. Then S_IF.
- S_IEX(11): ALUSrc_A=1, ALUSrc_B=10, ALU_Control=010 (addi) or 111 (slti). Then S_IWB.
- S_IWB(12): RegDst=00, MemtoReg=00, RegWrite=1. Then S_IF.
- S_TRAP(13): illegal=1 for exactly one cycle, all writes 0. Then S_IF.
- States 14 and 15 are unreachable; if entered they go to S_IF with all outputs 0.
- OP and Fun are sampled only in S_ID, S_MA, S_REX, S_BR and S_IEX. The instruction register is stable after S_IF.
- Cycle counts with MIO_ready held high:
  - lw: 5.
  - sw: 4.
  - R-type and I-type ALU: 4.
  - branch, j, jal: 3.
- Each stalled memory cycle adds 1.

Decomposition:
- Shared package mc_ctrl_pkg holds the state encodings, OP/Fun constants, ALU_Control codes, and the mux select encodings.
- One combinational sub-module, alu_ctrl_dec, maps (state class, OP, Fun) to ALU_Control and a legal flag.

Test Plan:
- rst=1 with MIO_ready=1 -> state_out=0 and PCWrite=IRWrite=RegWrite=MemWrite=0. Release rst -> PCWrite=1 in the first cycle.
- add r3,r2,r2 (OP=0, Fun=100000), MIO_ready=1 -> states 0,1,6,7. ALU_Control=010 in S_REX. RegWrite=1 with RegDst=01 in cycle 4 only.
- lw with MIO_ready low for 2 cycles in S_MR -> 7 cycles total. MemRead=1 and IorD=1 held throughout the stall. RegWrite=1 with MemtoReg=01 at the end.
- beq (OP=000100) -> Branch=1, BranchN=0, PCSource=01 in S_BR. bne -> BranchN=1, Branch=0.
- OP=111111, or OP=0 with Fun=001000 -> illegal=1 for one cycle in S_TRAP, no writes, then IF.
- jal -> S_JAL asserts PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10. Asserting rst during S_MW -> MemWrite drops immediately and state_out=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_t     : controller state encodings (visible on state_out)
//   - OP_* / FUN_*: opcode and R-type function field values
//   - ALU_*       : ALU_Control operation codes
//   - PCS_*, SRCA_*, SRCB_*, DST_*, WB_*: datapath mux select encodings
//   - CLS_*       : which rule picks ALU_Control in the current state
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MA   = 4'd2,
    S_MR   = 4'd3,
    S_LWB  = 4'd4,
    S_MW   = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_J    = 4'd9,
    S_JAL  = 4'd10,
    S_IEX  = 4'd11,
    S_IWB  = 4'd12,
    S_TRAP = 4'd13,
    S_U14  = 4'd14,
    S_U15  = 4'd15
  } state_t;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FUN_ADD = 6'b100000;
  localparam logic [5:0] FUN_SUB = 6'b100010;
  localparam logic [5:0] FUN_AND = 6'b100100;
  localparam logic [5:0] FUN_OR  = 6'b100101;
  localparam logic [5:0] FUN_XOR = 6'b100110;
  localparam logic [5:0] FUN_NOR = 6'b100111;
  localparam logic [5:0] FUN_SLT = 6'b101010;
  localparam logic [5:0] FUN_SRL = 6'b000010;

  // ALU_Control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // ALU operand selects
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // Register destination select
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // Write-back data select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // ALU control class of the current state
  localparam logic [2:0] CLS_NONE  = 3'd0;
  localparam logic [2:0] CLS_ADD   = 3'd1;
  localparam logic [2:0] CLS_SUB   = 3'd2;
  localparam logic [2:0] CLS_RTYPE = 3'd3;
  localparam logic [2:0] CLS_ITYPE = 3'd4;

  // Loads and stores share the address-calculation state.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_alu_dec.sv
// alu_ctrl_dec: combinational ALU control decoder.
//   cls         in  3  ALU control class of the current state (CLS_*)
//   op          in  6  instruction opcode
//   fun         in  6  R-type function field
//   alu_control out 3  ALU operation for the datapath
//   fun_legal   out 1  fun is one of the supported R-type functions
// fun_legal depends only on fun so the ID state can use it to pick
// between S_REX and S_TRAP regardless of the class it presents.
module alu_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] cls,
  input  logic [5:0] op,
  input  logic [5:0] fun,
  output logic [2:0] alu_control,
  output logic       fun_legal
);

  logic [2:0] r_code;

  always_comb begin
    r_code    = ALU_AND;
    fun_legal = 1'b1;
    case (fun)
      FUN_ADD: r_code = ALU_ADD;
      FUN_SUB: r_code = ALU_SUB;
      FUN_AND: r_code = ALU_AND;
      FUN_OR:  r_code = ALU_OR;
      FUN_XOR: r_code = ALU_XOR;
      FUN_NOR: r_code = ALU_NOR;
      FUN_SLT: r_code = ALU_SLT;
      FUN_SRL: r_code = ALU_SRL;
      default: fun_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALU_AND;
    case (cls)
      CLS_ADD:   alu_control = ALU_ADD;
      CLS_SUB:   alu_control = ALU_SUB;
      CLS_RTYPE: alu_control = r_code;
      CLS_ITYPE: alu_control = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default:   alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS control FSM driving the datapath.
//   clk, rst      : clock (rising edge), async active-high reset
//   OP, Fun       : instruction[31:26] and instruction[5:0]
//   MIO_ready     : memory transfer completes this cycle
//   MemRead, MemWrite, IorD, IRWrite        : memory/IR controls
//   PCWrite, Branch, BranchN, PCSource      : PC update controls
//   ALUSrc_A, ALUSrc_B, ALU_Control         : ALU operand/op controls
//   RegDst, MemtoReg, RegWrite              : register write-back controls
//   illegal       : one-cycle pulse on an undecodable instruction
//   state_out     : current state, for debug
// Moore machine except IRWrite/PCWrite in S_IF, which follow MIO_ready
// so the fetch commits in the cycle the memory answers.
//
// Handshake: MIO_ready is a completion strobe. In S_IF, S_MR and S_MW the
// request (MemRead/MemWrite with its address select) is held steady every
// cycle until MIO_ready=1 is seen at a rising clock edge; that edge
// completes the transfer and the FSM leaves the state. MIO_ready is
// ignored in all other states.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchN,
  output logic [1:0] PCSource,
  output logic       ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [2:0] ALU_Control,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state_out
);

  state_t     state;
  state_t     next_state;
  logic [2:0] alu_cls;
  logic       fun_legal;

  // Write enables before reset gating.
  logic ir_write_c;
  logic pc_write_c;
  logic reg_write_c;
  logic mem_write_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= next_state;
  end

  // ALU class depends only on state; kept apart from the main decode so
  // the decoder output does not loop back through one combinational block.
  always_comb begin
    alu_cls = CLS_NONE;
    case (state)
      S_IF, S_ID, S_MA: alu_cls = CLS_ADD;
      S_BR:             alu_cls = CLS_SUB;
      S_REX:            alu_cls = CLS_RTYPE;
      S_IEX:            alu_cls = CLS_ITYPE;
      default:          alu_cls = CLS_NONE;
    endcase
  end

  alu_ctrl_dec u_alu_dec (
    .cls         (alu_cls),
    .op          (OP),
    .fun         (Fun),
    .alu_control (ALU_Control),
    .fun_legal   (fun_legal)
  );

  always_comb begin
    next_state  = S_IF;
    MemRead     = 1'b0;
    IorD        = 1'b0;
    Branch      = 1'b0;
    BranchN     = 1'b0;
    PCSource    = PCS_ALU;
    ALUSrc_A    = SRCA_PC;
    ALUSrc_B    = SRCB_REG;
    RegDst      = DST_RT;
    MemtoReg    = WB_ALUOUT;
    illegal     = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;

    case (state)
      S_IF: begin
        MemRead    = 1'b1;
        ALUSrc_B   = SRCB_FOUR;
        ir_write_c = MIO_ready;
        pc_write_c = MIO_ready;
        next_state = MIO_ready ? S_ID : S_IF;
      end

      S_ID: begin
        // ALUOut captures PC+4 + (imm<<2) here for a possible branch.
        ALUSrc_B = SRCB_IMM_SL2;
        case (OP)
          OP_LW, OP_SW:      next_state = S_MA;
          OP_RTYPE:          next_state = fun_legal ? S_REX : S_TRAP;
          OP_BEQ, OP_BNE:    next_state = S_BR;
          OP_J:              next_state = S_J;
          OP_JAL:            next_state = S_JAL;
          OP_ADDI, OP_SLTI:  next_state = S_IEX;
          default:           next_state = S_TRAP;
        endcase
      end

      S_MA: begin
        ALUSrc_A   = SRCA_REG;
        ALUSrc_B   = SRCB_IMM;
        next_state = (OP == OP_LW) ? S_MR : S_MW;
      end

      S_MR: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MIO_ready ? S_LWB : S_MR;
      end

      S_LWB: begin
        RegDst      = DST_RT;
        MemtoReg    = WB_MDR;
        reg_write_c = 1'b1;
      end

      S_MW: begin
        mem_write_c = 1'b1;
        IorD        = 1'b1;
        next_state  = MIO_ready ? S_IF : S_MW;
      end

      S_REX: begin
        ALUSrc_A   = SRCA_REG;
        ALUSrc_B   = SRCB_REG;
        next_state = S_RWB;
      end

      S_RWB: begin
        RegDst      = DST_RD;
        MemtoReg    = WB_ALUOUT;
        reg_write_c = 1'b1;
      end

      S_BR: begin
        // Zero flag comes from A-B; target was left in ALUOut by S_ID.
        ALUSrc_A = SRCA_REG;
        ALUSrc_B = SRCB_REG;
        PCSource = PCS_ALUOUT;
        Branch   = (OP == OP_BEQ);
        BranchN  = (OP == OP_BNE);
      end

      S_J: begin
        PCSource   = PCS_JUMP;
        pc_write_c = 1'b1;
      end

      S_JAL: begin
        // PC already holds the return address (PC+4) from the fetch.
        PCSource    = PCS_JUMP;
        pc_write_c  = 1'b1;
        RegDst      = DST_RA;
        MemtoReg    = WB_PC;
        reg_write_c = 1'b1;
      end

      S_IEX: begin
        ALUSrc_A   = SRCA_REG;
        ALUSrc_B   = SRCB_IMM;
        next_state = S_IWB;
      end

      S_IWB: begin
        RegDst      = DST_RT;
        MemtoReg    = WB_ALUOUT;
        reg_write_c = 1'b1;
      end

      S_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
        next_state = S_IF;
      end
    endcase
  end

  // Reset is asynchronous, so the FSM already sits in S_IF while rst is
  // high; gating here keeps the Mealy fetch writes from firing then.
  assign IRWrite  = ir_write_c  & ~rst;
  assign PCWrite  = pc_write_c  & ~rst;
  assign RegWrite = reg_write_c & ~rst;
  assign MemWrite = mem_write_c & ~rst;

  assign state_out = state;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Testbench for mc_ctrl_unit. For each instruction the bench expands the
// instruction class into its list of phases (fetch, decode, execute,
// memory, write-back) with the expected control word for each cycle,
// including the stall cycles it chooses to inject, and compares the DUT
// cycle by cycle.
module tb_mc_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [5:0] OP;
  logic [5:0] Fun;
  logic       MIO_ready;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, BranchN;
  logic [1:0] PCSource;
  logic       ALUSrc_A;
  logic [1:0] ALUSrc_B;
  logic [2:0] ALU_Control;
  logic [1:0] RegDst, MemtoReg;
  logic       RegWrite, illegal;
  logic [3:0] state_out;

  mc_ctrl_unit #(.RESET_STATE(4'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .OP          (OP),
    .Fun         (Fun),
    .MIO_ready   (MIO_ready),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .Branch      (Branch),
    .BranchN     (BranchN),
    .PCSource    (PCSource),
    .ALUSrc_A    (ALUSrc_A),
    .ALUSrc_B    (ALUSrc_B),
    .ALU_Control (ALU_Control),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .illegal     (illegal),
    .state_out   (state_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, iord, irw, pcw, br, brn;
    logic [1:0] pcs;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] dst, m2r;
    logic       rw, ill;
  } exp_t;

  logic [24:0] exp_q[$];
  logic        rdy_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  string       tag;

  function automatic logic [24:0] obs_vec();
    return {state_out, MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch,
            BranchN, PCSource, ALUSrc_A, ALUSrc_B, ALU_Control, RegDst,
            MemtoReg, RegWrite, illegal};
  endfunction

  // R-type function table: {legal, ALU code}
  function automatic logic [3:0] ref_fun(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b100110: return 4'b1_011;
      6'b100111: return 4'b1_100;
      6'b101010: return 4'b1_111;
      6'b000010: return 4'b1_101;
      default:   return 4'b0_000;
    endcase
  endfunction

  function automatic logic op_known(input logic [5:0] o);
    case (o)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
      6'b001000, 6'b001010, 6'b100011, 6'b101011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic emit(input logic [3:0] st, input logic rdy);
    e.st = st;
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    e = '0;
  endtask

  // Expand one instruction into its expected per-cycle control words.
  task automatic build(input logic [5:0] op, input logic [5:0] fun,
                       input int s_if, input int s_mem);
    logic [3:0] rf;
    rf = ref_fun(fun);
    e = '0;
    for (int i = 0; i < s_if; i++) begin
      e.mr = 1; e.srcb = 2'b01; e.alu = 3'b010; emit(4'd0, 1'b0);
    end
    e.mr = 1; e.srcb = 2'b01; e.alu = 3'b010; e.irw = 1; e.pcw = 1;
    emit(4'd0, 1'b1);
    e.srcb = 2'b11; e.alu = 3'b010; emit(4'd1, 1'($urandom_range(0, 1)));
    if (op == 6'b100011 || op == 6'b101011) begin
      e.srca = 1; e.srcb = 2'b10; e.alu = 3'b010;
      emit(4'd2, 1'($urandom_range(0, 1)));
      for (int i = 0; i <= s_mem; i++) begin
        e.iord = 1;
        if (op == 6'b100011) begin e.mr = 1; emit(4'd3, i == s_mem); end
        else                 begin e.mw = 1; emit(4'd5, i == s_mem); end
      end
      if (op == 6'b100011) begin
        e.m2r = 2'b01; e.rw = 1; emit(4'd4, 1'($urandom_range(0, 1)));
      end
    end else if (op == 6'b000000 && rf[3]) begin
      e.srca = 1; e.alu = rf[2:0]; emit(4'd6, 1'($urandom_range(0, 1)));
      e.dst = 2'b01; e.rw = 1; emit(4'd7, 1'($urandom_range(0, 1)));
    end else if (op == 6'b000100 || op == 6'b000101) begin
      e.srca = 1; e.alu = 3'b110; e.pcs = 2'b01;
      e.br = (op == 6'b000100); e.brn = (op == 6'b000101);
      emit(4'd8, 1'($urandom_range(0, 1)));
    end else if (op == 6'b000010) begin
      e.pcs = 2'b10; e.pcw = 1; emit(4'd9, 1'($urandom_range(0, 1)));
    end else if (op == 6'b000011) begin
      e.pcs = 2'b10; e.pcw = 1; e.dst = 2'b10; e.m2r = 2'b10; e.rw = 1;
      emit(4'd10, 1'($urandom_range(0, 1)));
    end else if (op == 6'b001000 || op == 6'b001010) begin
      e.srca = 1; e.srcb = 2'b10; e.alu = (op == 6'b001010) ? 3'b111 : 3'b010;
      emit(4'd11, 1'($urandom_range(0, 1)));
      e.rw = 1; emit(4'd12, 1'($urandom_range(0, 1)));
    end else begin
      e.ill = 1; emit(4'd13, 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the next falling edge.
  task automatic step();
    logic [24:0] ex;
    logic [24:0] ob;
    MIO_ready = rdy_q.pop_front();
    ex = exp_q.pop_front();
    #1;
    ob = obs_vec();
    checks++;
    assert (ob[24:21] === ex[24:21]) else begin
      errors++;
      $error("FAIL %s state: observed=%0d expected=%0d", tag, ob[24:21], ex[24:21]);
    end
    checks++;
    assert (ob[20:0] === ex[20:0]) else begin
      errors++;
      $error("FAIL %s ctl(st=%0d): observed=%h expected=%h", tag, ex[24:21], ob[20:0], ex[20:0]);
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input string t, input logic [5:0] op,
                           input logic [5:0] fun, input int s_if, input int s_mem);
    tag = t;
    OP  = op;
    Fun = fun;
    build(op, fun, s_if, s_mem);
    while (exp_q.size() > 0) step();
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] legal_funs [8];
  logic [5:0] rop, rfun;
  int         kind;

  initial begin
    legal_funs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                   6'b100110, 6'b100111, 6'b101010, 6'b000010};
    rst = 1'b1; MIO_ready = 1'b1; OP = 6'b0; Fun = 6'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++;
    assert ({state_out, PCWrite, IRWrite, RegWrite, MemWrite} === 8'h00) else begin
      errors++;
      $error("FAIL reset_hold: observed=%h expected=%h",
             {state_out, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    assert (PCWrite === 1'b1) else begin
      errors++;
      $error("FAIL reset_release_pcwrite: observed=%b expected=1", PCWrite);
    end

    // directed instructions
    run_instr("add",      6'b000000, 6'b100000, 0, 0);
    run_instr("lw_stall", 6'b100011, 6'b000000, 0, 2);
    run_instr("beq",      6'b000100, 6'b000000, 0, 0);
    run_instr("bne",      6'b000101, 6'b111111, 1, 0);
    run_instr("ill_op",   6'b111111, 6'b000000, 0, 0);
    run_instr("ill_fun",  6'b000000, 6'b001000, 0, 0);
    run_instr("jal",      6'b000011, 6'b000000, 0, 0);
    run_instr("j",        6'b000010, 6'b000000, 2, 0);
    run_instr("sw",       6'b101011, 6'b000000, 0, 1);
    run_instr("addi",     6'b001000, 6'b000000, 0, 0);
    run_instr("slti",     6'b001010, 6'b000000, 0, 0);
    for (int i = 0; i < 8; i++) run_instr("rtype_tbl", 6'b000000, legal_funs[i], 0, 0);

    // reset during a stalled store
    tag = "sw_abort";
    OP = 6'b101011; Fun = 6'b0;
    build(6'b101011, 6'b0, 0, 3);
    for (int i = 0; i < 3; i++) step();
    MIO_ready = 1'b0;
    #1;
    checks++;
    assert ({state_out, MemWrite} === {4'd5, 1'b1}) else begin
      errors++;
      $error("FAIL sw_abort_before: observed=%h expected=%h", {state_out, MemWrite}, {4'd5, 1'b1});
    end
    rst = 1'b1;
    #1;
    checks++;
    assert ({state_out, MemWrite} === 5'h00) else begin
      errors++;
      $error("FAIL sw_abort_after: observed=%h expected=%h", {state_out, MemWrite}, 5'h00);
    end
    exp_q.delete();
    rdy_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_instr("post_abort", 6'b000000, 6'b100010, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 11);
      rfun = 6'($urandom);
      case (kind)
        0:  rop = 6'b100011;
        1:  rop = 6'b101011;
        2, 11: begin rop = 6'b000000; rfun = legal_funs[$urandom_range(0, 7)]; end
        3:  rop = 6'b000100;
        4:  rop = 6'b000101;
        5:  rop = 6'b000010;
        6:  rop = 6'b000011;
        7:  rop = 6'b001000;
        8:  rop = 6'b001010;
        9: begin
          rop = 6'b000000;
          for (int t = 0; t < 50 && ref_fun(rfun)[3]; t++) rfun = 6'($urandom);
          if (ref_fun(rfun)[3]) rfun = 6'b111111;
        end
        default: begin
          rop = 6'($urandom);
          for (int t = 0; t < 50 && op_known(rop); t++) rop = 6'($urandom);
          if (op_known(rop)) rop = 6'b111111;
        end
      endcase
      run_instr("random", rop, rfun, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
